fb_ddram_writer: RTL and testbench
==================================

FB_DDRAM_WRITER -- requirements
Module: fb_ddram_writer

Interface
REQ-001 The block SHALL have parameter FB_BASE, default 27'h0400000, meaning buffer-0 base address in [27:1] halfword units (byte 0x800000).
REQ-002 The block SHALL have parameter BUF_STRIDE, default 27'h0020000, meaning offset between buffer 0 and buffer 1 in [27:1] units (256 KiB).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning word-FIFO entries (power of two).
REQ-004 DDRAM_CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse marking start of a new 240x160 frame.
REQ-007 pix_en  in  1  pixel valid strobe, one pixel per asserted cycle, raster order.
REQ-008 pix_data  in  15  RGB555 pixel.
REQ-009 ch_addr  out  27  DDRAM channel write address, [27:1] units.
REQ-010 ch_din  out  64  DDRAM channel write data.
REQ-011 ch_req  out  1  one-cycle write request pulse.
REQ-012 ch_ready  in  1  one-cycle acceptance pulse from the DDRAM arbiter.
REQ-013 display_buf  out  1  index of the most recently completed buffer.
REQ-014 frame_done  out  1  one-cycle pulse when a frame's last word is accepted.
REQ-015 err_drop  out  1  sticky: pixel dropped (FIFO full or >38400 pixels in frame).
REQ-016 err_partial  out  1  sticky: frame_start arrived with a partially packed word.

Function
REQ-017 Pixel counter SHALL run 0..38399 per frame; pix_en at count 38400 SHALL drop the pixel and set err_drop.
REQ-018 Pixel n SHALL be stored as {1'b0, pix_data} in bits [16*(n%4)+15 : 16*(n%4)] of the packing register.
REQ-019 On the 4th pixel of a group the packed word SHALL be pushed to the FIFO in the same cycle with addr = FB_BASE + write_buf*BUF_STRIDE + 4*word_index, tag buf = write_buf, and last = (word_index == 9599).
REQ-020 Push while FIFO full SHALL discard the whole word, set err_drop, and still advance the counters.
REQ-021 frame_start SHALL zero pixel/word counters, clear the packer, and toggle write_buf; a non-empty packer at that moment SHALL be discarded and set err_partial.
REQ-022 frame_start and pix_en in the same cycle: frame_start is applied first; that pixel is pixel 0 of the new frame.
REQ-023 Entries already in the FIFO SHALL drain with their stored address and tag, unaffected by frame_start.
REQ-024 Request FSM states: IDLE, WAIT.
REQ-025 IDLE: FIFO non-empty -> ch_addr/ch_din driven from FIFO head, ch_req = 1 for exactly one cycle, go to WAIT.
REQ-026 WAIT: ch_req = 0; ch_addr/ch_din held stable; on ch_ready pop FIFO, go to IDLE.
REQ-027 At most one request outstanding; minimum two cycles between ch_req pulses.
REQ-028 ch_ready while in IDLE SHALL be ignored (no pop, no error).
REQ-029 On acceptance of an entry with last = 1: display_buf <= entry buf and frame_done = 1 the next cycle.
REQ-030 FIFO push and pop in the same cycle SHALL keep occupancy unchanged; full/empty flags SHALL be exact.

Reset
REQ-031 reset SHALL clear the FIFO, counters, packer, write_buf, display_buf, err_drop, err_partial and return the FSM to IDLE.
REQ-032 During and after reset: ch_req = 0, frame_done = 0, ch_addr = 0, ch_din = 0 until the first request.
REQ-033 reset asserted while in WAIT SHALL abandon the outstanding request; a subsequent stale ch_ready SHALL be ignored per REQ-028.

Verification
REQ-034 Reset; frame_start; 4 pixels 0x0001..0x0004; ch_ready 2 cycles after ch_req -> one ch_req, ch_addr = 27'h0420000 (write_buf = 1 after toggle), ch_din = 64'h0004_0003_0002_0001.
REQ-035 Full 38400-pixel frame, ch_ready always 1 cycle after ch_req -> 9600 requests, addresses step by 4, frame_done once, display_buf toggles to 1, no errors.
REQ-036 Withhold ch_ready for 100 cycles while streaming pixels every cycle -> FIFO holds 8 words, further words dropped, err_drop = 1, no ch_req while in WAIT.
REQ-037 frame_start after 6 pixels -> err_partial = 1, one word issued, next frame's first word at ch_addr = FB_BASE (buffer 0).
REQ-038 reset mid-WAIT, then ch_ready pulse -> no pop, ch_req stays 0, all outputs at reset values.

Source files
------------

// File: rtl/fb_ddram_writer.sv
// fb_ddram_writer: packs RGB555 pixels four to a 64-bit word, queues each word
// with its framebuffer address and issues the words as single DDRAM channel
// writes, double-buffering between two framebuffers.
module fb_ddram_writer #(
  parameter logic [26:0] FB_BASE    = 27'h0400000,
  parameter logic [26:0] BUF_STRIDE = 27'h0020000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_en,
  input  logic [14:0] pix_data,
  output logic [26:0] ch_addr,
  output logic [63:0] ch_din,
  output logic        ch_req,
  input  logic        ch_ready,
  output logic        display_buf,
  output logic        frame_done,
  output logic        err_drop,
  output logic        err_partial
);

  localparam int          PW           = $clog2(FIFO_DEPTH);
  localparam int          ENTRY_W      = 93;
  localparam logic [15:0] FRAME_PIXELS = 16'd38400;
  localparam logic [13:0] LAST_WORD    = 14'd9599;
  localparam logic [PW:0] PTR_ONE      = {{PW{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        pixCnt_q, pixCnt_d;
  logic [47:0]        packer_q, packer_d;
  logic               writeBuf_q, writeBuf_d;
  logic               errDrop_q, errDrop_d;
  logic               errPartial_q, errPartial_d;
  logic [PW:0]        wrPtr_q, wrPtr_d;
  logic [PW:0]        rdPtr_q, rdPtr_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [26:0]        chAddr_q, chAddr_d;
  logic [63:0]        chDin_q, chDin_d;
  logic               chReq_q, chReq_d;
  logic               curBuf_q, curBuf_d;
  logic               curLast_q, curLast_d;
  logic               displayBuf_q, displayBuf_d;
  logic               frameDone_q, frameDone_d;

  logic [15:0]        curCnt;
  logic [13:0]        wordIdx;
  logic               pushReq;
  logic               pushAccept;
  logic               dropPix;
  logic               pop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [26:0]        bufOffset;
  logic [ENTRY_W-1:0] pushEntry;
  logic [ENTRY_W-1:0] headEntry;

  // Pixel packer: frame_start is applied before any pixel of the same cycle.
  // Only lanes 0..2 are stored; lane 3 goes straight into the pushed word.
  always_comb begin
    pixCnt_d     = pixCnt_q;
    packer_d     = packer_q;
    writeBuf_d   = writeBuf_q;
    errPartial_d = errPartial_q;
    curCnt       = pixCnt_q;
    dropPix      = 1'b0;
    pushReq      = 1'b0;
    if (frame_start) begin
      writeBuf_d = ~writeBuf_q;
      curCnt     = '0;
      pixCnt_d   = '0;
      packer_d   = '0;
      if (pixCnt_q[1:0] != 2'd0) begin
        errPartial_d = 1'b1;
      end
    end
    wordIdx = curCnt[15:2];
    if (pix_en) begin
      if (curCnt == FRAME_PIXELS) begin
        dropPix = 1'b1;
      end else begin
        pixCnt_d = curCnt + 16'd1;
        case (curCnt[1:0])
          2'd0:    packer_d[15:0]  = {1'b0, pix_data};
          2'd1:    packer_d[31:16] = {1'b0, pix_data};
          2'd2:    packer_d[47:32] = {1'b0, pix_data};
          default: pushReq         = 1'b1;
        endcase
      end
    end
  end

  assign bufOffset = writeBuf_d ? BUF_STRIDE : 27'd0;
  assign pushEntry = {(wordIdx == LAST_WORD), writeBuf_d,
                      FB_BASE + bufOffset + {11'd0, wordIdx, 2'b00},
                      1'b0, pix_data, packer_q};

  assign fifoEmpty  = (wrPtr_q == rdPtr_q);
  assign fifoFull   = (wrPtr_q[PW] != rdPtr_q[PW]) &&
                      (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
  assign pushAccept = pushReq && !fifoFull;
  assign headEntry  = mem_q[rdPtr_q[PW-1:0]];
  assign wrPtr_d    = pushAccept ? wrPtr_q + PTR_ONE : wrPtr_q;
  assign rdPtr_d    = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
  assign errDrop_d  = errDrop_q | dropPix | (pushReq & fifoFull);

  // Request FSM: launch one write from the FIFO head, then hold it until accepted.
  always_comb begin
    state_d      = state_q;
    chReq_d      = 1'b0;
    chAddr_d     = chAddr_q;
    chDin_d      = chDin_q;
    curBuf_d     = curBuf_q;
    curLast_d    = curLast_q;
    displayBuf_d = displayBuf_q;
    frameDone_d  = 1'b0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          chAddr_d  = headEntry[90:64];
          chDin_d   = headEntry[63:0];
          curBuf_d  = headEntry[91];
          curLast_d = headEntry[92];
          chReq_d   = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ch_ready) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
          if (curLast_q) begin
            displayBuf_d = curBuf_q;
            frameDone_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, flags, FIFO pointers and registered channel outputs.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      pixCnt_q     <= '0;
      packer_q     <= '0;
      writeBuf_q   <= 1'b0;
      errDrop_q    <= 1'b0;
      errPartial_q <= 1'b0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      chAddr_q     <= '0;
      chDin_q      <= '0;
      chReq_q      <= 1'b0;
      curBuf_q     <= 1'b0;
      curLast_q    <= 1'b0;
      displayBuf_q <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      pixCnt_q     <= pixCnt_d;
      packer_q     <= packer_d;
      writeBuf_q   <= writeBuf_d;
      errDrop_q    <= errDrop_d;
      errPartial_q <= errPartial_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      chAddr_q     <= chAddr_d;
      chDin_q      <= chDin_d;
      chReq_q      <= chReq_d;
      curBuf_q     <= curBuf_d;
      curLast_q    <= curLast_d;
      displayBuf_q <= displayBuf_d;
      frameDone_q  <= frameDone_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge DDRAM_CLK) begin
    if (!reset && pushAccept) begin
      mem_q[wrPtr_q[PW-1:0]] <= pushEntry;
    end
  end

  assign ch_addr     = chAddr_q;
  assign ch_din      = chDin_q;
  assign ch_req      = chReq_q;
  assign display_buf = displayBuf_q;
  assign frame_done  = frameDone_q;
  assign err_drop    = errDrop_q;
  assign err_partial = errPartial_q;

endmodule

// File: tb/tb_fb_ddram_writer.sv
// Directed self-checking bench for fb_ddram_writer.
module tb_fb_ddram_writer;

  logic        DDRAM_CLK = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        pix_en;
  logic [14:0] pix_data;
  logic [26:0] ch_addr;
  logic [63:0] ch_din;
  logic        ch_req;
  logic        ch_ready;
  logic        display_buf;
  logic        frame_done;
  logic        err_drop;
  logic        err_partial;

  int checks    = 0;
  int errors    = 0;
  int reqCount  = 0;
  int doneCount = 0;
  int r0;
  int d0;
  bit seen;

  localparam logic [26:0] BUF0 = 27'h0400000;
  localparam logic [26:0] BUF1 = 27'h0420000;

  fb_ddram_writer dut (
    .DDRAM_CLK   (DDRAM_CLK),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_en      (pix_en),
    .pix_data    (pix_data),
    .ch_addr     (ch_addr),
    .ch_din      (ch_din),
    .ch_req      (ch_req),
    .ch_ready    (ch_ready),
    .display_buf (display_buf),
    .frame_done  (frame_done),
    .err_drop    (err_drop),
    .err_partial (err_partial)
  );

  // Free-running clock.
  always #5 DDRAM_CLK = ~DDRAM_CLK;

  // Count request and frame_done pulses as they are sampled by the DUT edge.
  always @(posedge DDRAM_CLK) begin
    if (ch_req === 1'b1) reqCount++;
    if (frame_done === 1'b1) doneCount++;
  end

  function automatic logic [63:0] packWord(input logic [14:0] p0, input logic [14:0] p1,
                                           input logic [14:0] p2, input logic [14:0] p3);
    return {1'b0, p3, 1'b0, p2, 1'b0, p1, 1'b0, p0};
  endfunction

  function automatic logic [14:0] framePix(input int n);
    return 15'(n) ^ 15'h2AAA;
  endfunction

  task automatic step();
    @(posedge DDRAM_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic en, input logic [14:0] data);
    frame_start = fs;
    pix_en      = en;
    pix_data    = data;
    step();
    frame_start = 1'b0;
    pix_en      = 1'b0;
  endtask

  task automatic waitReq(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (ch_req === 1'b1) got = 1'b1;
      else step();
    end
  endtask

  task automatic pulseReady();
    ch_ready = 1'b1;
    step();
    ch_ready = 1'b0;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    frame_start = 1'b0;
    pix_en      = 1'b0;
    pix_data    = '0;
    ch_ready    = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    // Reset values.
    doReset();
    $display("[TB] reset values");
    checkOutput("rstReq", ch_req, 1'b0);
    checkOutput("rstAddr", ch_addr, 27'd0);
    checkOutput("rstDin", ch_din, 64'd0);
    checkOutput("rstDone", frame_done, 1'b0);
    checkOutput("rstDisp", display_buf, 1'b0);
    checkOutput("rstDrop", err_drop, 1'b0);
    checkOutput("rstPartial", err_partial, 1'b0);

    // Single word into buffer 1; stray ready in IDLE is ignored.
    $display("[TB] single word");
    r0 = reqCount;
    d0 = doneCount;
    pulseReady();
    step();
    applyStimulus(1'b1, 1'b0, 15'h0);
    applyStimulus(1'b0, 1'b1, 15'h0001);
    applyStimulus(1'b0, 1'b1, 15'h0002);
    applyStimulus(1'b0, 1'b1, 15'h0003);
    applyStimulus(1'b0, 1'b1, 15'h0004);
    waitReq(8, seen);
    checkOutput("w1Seen", seen, 1'b1);
    checkOutput("w1Addr", ch_addr, BUF1);
    checkOutput("w1Din", ch_din, 64'h0004_0003_0002_0001);
    step();
    checkOutput("w1ReqOnePulse", ch_req, 1'b0);
    checkOutput("w1AddrHeld", ch_addr, BUF1);
    step();
    pulseReady();
    repeat (6) step();
    checkOutput("w1ReqCount", reqCount - r0, 1);
    checkOutput("w1NoDone", doneCount - d0, 0);
    checkOutput("w1Partial", err_partial, 1'b0);

    // Partial word discarded at frame_start; next frame starts at buffer 0,
    // with frame_start and the first pixel in the same cycle.
    $display("[TB] partial word");
    doReset();
    applyStimulus(1'b1, 1'b0, 15'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 15'(16 + i));
    applyStimulus(1'b1, 1'b1, 15'h0020);
    applyStimulus(1'b0, 1'b1, 15'h0021);
    applyStimulus(1'b0, 1'b1, 15'h0022);
    applyStimulus(1'b0, 1'b1, 15'h0023);
    checkOutput("pPartial", err_partial, 1'b1);
    checkOutput("pDrop", err_drop, 1'b0);
    checkOutput("pReqLow", ch_req, 1'b0);
    checkOutput("pAddr0", ch_addr, BUF1);
    checkOutput("pDin0", ch_din, packWord(15'h10, 15'h11, 15'h12, 15'h13));
    pulseReady();
    waitReq(8, seen);
    checkOutput("pSeen1", seen, 1'b1);
    checkOutput("pAddr1", ch_addr, BUF0);
    checkOutput("pDin1", ch_din, packWord(15'h20, 15'h21, 15'h22, 15'h23));
    step();
    pulseReady();
    repeat (6) step();
    checkOutput("pIdle", ch_req, 1'b0);

    // Backpressure: 100 pixels with no acceptance fill the FIFO with 8 words.
    $display("[TB] backpressure");
    doReset();
    applyStimulus(1'b1, 1'b0, 15'h0);
    r0 = reqCount;
    for (int n = 0; n < 100; n++) applyStimulus(1'b0, 1'b1, 15'(256 + n));
    checkOutput("bpReqCount", reqCount - r0, 1);
    checkOutput("bpDrop", err_drop, 1'b1);
    checkOutput("bpReqLow", ch_req, 1'b0);
    checkOutput("bpAddrHeld", ch_addr, BUF1);
    checkOutput("bpDinHeld", ch_din, packWord(15'd256, 15'd257, 15'd258, 15'd259));
    pulseReady();
    for (int k = 1; k < 8; k++) begin
      waitReq(8, seen);
      checkOutput("bpSeen", seen, 1'b1);
      checkOutput("bpAddr", ch_addr, BUF1 + 27'(4 * k));
      checkOutput("bpDin", ch_din, packWord(15'(256 + 4 * k), 15'(257 + 4 * k),
                                            15'(258 + 4 * k), 15'(259 + 4 * k)));
      step();
      pulseReady();
    end
    repeat (10) step();
    checkOutput("bpTotalReqs", reqCount - r0, 8);

    // Reset while a request is outstanding, then a stale ready.
    $display("[TB] reset in WAIT");
    doReset();
    applyStimulus(1'b1, 1'b0, 15'h0);
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1, 15'(n + 5));
    waitReq(8, seen);
    checkOutput("rwSeen", seen, 1'b1);
    reset = 1'b1;
    step();
    checkOutput("rwDuringReq", ch_req, 1'b0);
    checkOutput("rwDuringAddr", ch_addr, 27'd0);
    step();
    reset = 1'b0;
    step();
    r0 = reqCount;
    d0 = doneCount;
    pulseReady();
    repeat (10) step();
    checkOutput("rwNoReq", reqCount - r0, 0);
    checkOutput("rwReq", ch_req, 1'b0);
    checkOutput("rwAddr", ch_addr, 27'd0);
    checkOutput("rwDin", ch_din, 64'd0);
    checkOutput("rwDisp", display_buf, 1'b0);
    checkOutput("rwDone", doneCount - d0, 0);

    // Full frame into buffer 1 with acceptance one cycle after each request.
    $display("[TB] full frame");
    doReset();
    applyStimulus(1'b1, 1'b0, 15'h0);
    r0 = reqCount;
    d0 = doneCount;
    fork
      begin
        for (int n = 0; n < 38400; n++) applyStimulus(1'b0, 1'b1, framePix(n));
      end
      begin
        bit got;
        for (int k = 0; k < 9600; k++) begin
          waitReq(64, got);
          if (!got) begin
            checkOutput("ffSeen", got, 1'b1);
            break;
          end
          checkOutput("ffAddr", ch_addr, BUF1 + 27'(4 * k));
          checkOutput("ffDin", ch_din, packWord(framePix(4 * k), framePix(4 * k + 1),
                                                framePix(4 * k + 2), framePix(4 * k + 3)));
          step();
          pulseReady();
        end
      end
    join
    repeat (4) step();
    checkOutput("ffReqs", reqCount - r0, 9600);
    checkOutput("ffDoneOnce", doneCount - d0, 1);
    checkOutput("ffDisp", display_buf, 1'b1);
    checkOutput("ffDrop", err_drop, 1'b0);
    checkOutput("ffPartial", err_partial, 1'b0);
    applyStimulus(1'b0, 1'b1, 15'h1234);
    step();
    checkOutput("ffOverflowDrop", err_drop, 1'b1);
    repeat (8) step();
    checkOutput("ffOverflowNoReq", reqCount - r0, 9600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
